// File: rtl/d_ff_resp_checker.sv
// rtl/d_ff_resp_checker.sv - D->Q response checker for flip-flop DUTs (optional DFFCHK_STOP_ON_ERR_EN)
module d_ff_resp_checker #(
  parameter int DELAY = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             d_in,
  input  logic             q_in,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             done,
  output logic             pass
);

  localparam int FW = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] first_err_idx_q;
  logic [DELAY-1:0] dly_q;
  logic [FW-1:0]    fill_cnt_q;
  logic             busy_q;
  logic             mismatch_q;
  logic             done_q;
  logic             pass_q;

  logic             exp_bit;
  logic             miscmp_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             last_cmp;
  logic             end_run_d;

  // Compare of the current CHECK cycle and the resulting counter/termination values
  always_comb begin
    exp_bit   = dly_q[DELAY-1];
    // case inequality so an X/Z on Q is flagged rather than silently matching
    miscmp_d  = (q_in !== exp_bit);
    err_cnt_d = err_cnt_q;
    if (miscmp_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    last_cmp  = (bit_idx_q == (len_q - 1'b1));
`ifdef DFFCHK_STOP_ON_ERR_EN
    end_run_d = last_cmp | miscmp_d;
`else
    end_run_d = last_cmp;
`endif
  end

  // Run sequencing FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      bit_idx_q       <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      dly_q           <= '0;
      fill_cnt_q      <= '0;
      busy_q          <= 1'b0;
      mismatch_q      <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q           <= len;
            dly_q           <= '0;
            err_cnt_q       <= '0;
            first_err_idx_q <= '0;
            bit_idx_q       <= '0;
            fill_cnt_q      <= '0;
            pass_q          <= 1'b0;
            if (len != '0) begin
              state_q <= S_FILL;
              busy_q  <= 1'b1;
            end else begin
              // empty run: nothing to compare, so it trivially passes
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          dly_q <= (dly_q << 1) | DELAY'(d_in);
          if (fill_cnt_q == FW'(DELAY - 1)) begin
            state_q <= S_CHECK;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          dly_q      <= (dly_q << 1) | DELAY'(d_in);
          mismatch_q <= miscmp_d;
          err_cnt_q  <= err_cnt_d;
          if (miscmp_d && (err_cnt_q == '0)) begin
            first_err_idx_q <= bit_idx_q;
          end
          if (end_run_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign mismatch      = mismatch_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_d_ff_resp_checker.sv
// tb/tb_d_ff_resp_checker.sv - scoreboard bench for d_ff_resp_checker
module tb_d_ff_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_r;
  logic [7:0] len_r;
  logic       d_in;
  logic       q_in;

  logic       obs_busy [3];
  logic       obs_mis  [3];
  logic       obs_done [3];
  logic       obs_pass [3];
  logic [7:0] obs_err  [3];
  logic [7:0] obs_first[3];
  logic [3:0] err2;
  logic [3:0] first2;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  // u0: single DFF checker, u1: two-cycle latency checker, u2: 4-bit counters
  d_ff_resp_checker #(.DELAY(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .len(len_r), .d_in(d_in), .q_in(q_in),
    .busy(obs_busy[0]), .mismatch(obs_mis[0]), .err_cnt(obs_err[0]),
    .first_err_idx(obs_first[0]), .done(obs_done[0]), .pass(obs_pass[0]));

  d_ff_resp_checker #(.DELAY(2), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .len(len_r), .d_in(d_in), .q_in(q_in),
    .busy(obs_busy[1]), .mismatch(obs_mis[1]), .err_cnt(obs_err[1]),
    .first_err_idx(obs_first[1]), .done(obs_done[1]), .pass(obs_pass[1]));

  d_ff_resp_checker #(.DELAY(1), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start_r[2]), .len(len_r[3:0]), .d_in(d_in), .q_in(q_in),
    .busy(obs_busy[2]), .mismatch(obs_mis[2]), .err_cnt(err2),
    .first_err_idx(first2), .done(obs_done[2]), .pass(obs_pass[2]));

  assign obs_err[2]   = {4'b0, err2};
  assign obs_first[2] = {4'b0, first2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run on DUT sel. The bench plays the role of the DUT under test: Q is D
  // delayed by qlat, optionally inverted everywhere, inverted at index bad, or X at index xbad.
  task automatic run(input int sel, input int dly, input int qlat, input int n,
                     input logic [15:0] dbits, input logic inv_all, input int bad,
                     input int xbad, input int restart_c, input int rst_idx, input int satmax);
    logic dh[0:63];
    logic qv;
    logic m;
    logic ended;
    bit   stop_mode;
    int   exp_err;
    int   exp_first;
    int   i;
`ifdef DFFCHK_STOP_ON_ERR_EN
    stop_mode = 1'b1;
`else
    stop_mode = 1'b0;
`endif
    dh[0] = 1'b0;
    for (int c = 1; c < 64; c++) dh[c] = (c - 1 < n) ? dbits[c-1] : ((n > 0) ? dbits[n-1] : 1'b0);
    exp_err   = 0;
    exp_first = 0;
    exp_q.delete();

    start_r[sel] = 1'b1;
    len_r        = 8'(n);
    d_in         = 1'b0;
    q_in         = 1'b0;
    @(posedge clk); #1;
    start_r = '0;
    chk($sformatf("busy_after_start%0d", sel), 32'(obs_busy[sel]), 32'(n != 0));
    if (n == 0) begin
      chk("len0_done", 32'(obs_done[sel]), 1);
      chk("len0_pass", 32'(obs_pass[sel]), 1);
      @(posedge clk); #1;
      chk("len0_done_low", 32'(obs_done[sel]), 0);
      chk("len0_busy_low", 32'(obs_busy[sel]), 0);
      return;
    end

    ended = 1'b0;
    for (int c = 1; !ended && c < 60; c++) begin
      i    = c - 1 - dly;
      d_in = dh[c];
      qv   = (c - qlat >= 1) ? dh[c-qlat] : 1'b0;
      if (i == bad) qv = ~qv;
      if (inv_all)  qv = ~qv;
      if (i == xbad) qv = 1'bx;
      q_in = qv;
      if (c == restart_c) begin
        start_r[sel] = 1'b1;
        len_r        = 8'd3;
      end
      if (i >= 0) exp_q.push_back(qv !== dh[i+1]);
      if (i == rst_idx) rst = 1'b1;
      @(posedge clk); #1;
      rst     = 1'b0;
      start_r = '0;
      if (i == rst_idx) begin
        chk("rst_busy", 32'(obs_busy[sel]), 0);
        chk("rst_err_cnt", 32'(obs_err[sel]), 0);
        chk("rst_pass", 32'(obs_pass[sel]), 0);
        chk("rst_done", 32'(obs_done[sel]), 0);
        exp_q.delete();
        repeat (3) begin
          @(posedge clk); #1;
          chk("rst_no_done", 32'(obs_done[sel]), 0);
          chk("rst_idle", 32'(obs_busy[sel]), 0);
        end
        return;
      end
      if (i >= 0) begin
        if (exp_q.size() == 0) begin
          chk("queue_empty", 0, 1);
          m = 1'b0;
        end else begin
          m = exp_q.pop_front();
        end
        chk($sformatf("mismatch_idx%0d", i), 32'(obs_mis[sel]), 32'(m));
        if (m) begin
          if (exp_err == 0) exp_first = i;
          if (exp_err < satmax) exp_err++;
        end
        ended = (i == n - 1) || (stop_mode && m);
      end
      chk($sformatf("done_c%0d", c), 32'(obs_done[sel]), 32'(ended));
      chk($sformatf("busy_c%0d", c), 32'(obs_busy[sel]), 32'(!ended));
    end
    if (!ended) chk("run_timeout", 0, 1);
    chk("err_cnt", 32'(obs_err[sel]), 32'(exp_err));
    chk("pass", 32'(obs_pass[sel]), 32'(exp_err == 0));
    if (exp_err != 0) chk("first_err_idx", 32'(obs_first[sel]), 32'(exp_first));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(obs_done[sel]), 0);
    chk("pass_held", 32'(obs_pass[sel]), 32'(exp_err == 0));
  endtask

  initial begin
    rst     = 1'b1;
    start_r = '0;
    len_r   = '0;
    d_in    = 1'b0;
    q_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_busy%0d", k), 32'(obs_busy[k]), 0);
      chk($sformatf("reset_done%0d", k), 32'(obs_done[k]), 0);
      chk($sformatf("reset_pass%0d", k), 32'(obs_pass[k]), 0);
      chk($sformatf("reset_err%0d", k), 32'(obs_err[k]), 0);
      chk($sformatf("reset_mis%0d", k), 32'(obs_mis[k]), 0);
      chk($sformatf("reset_first%0d", k), 32'(obs_first[k]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // ideal DFF, d=10110010, with an ignored start pulse mid-run
    run(0, 1, 1, 8, 16'b0000_0000_0100_1101, 1'b0, -1, -1, 4, -1, 255);
    // bit 3 of Q inverted
    run(0, 1, 1, 8, 16'b0000_0000_0100_1101, 1'b0, 3, -1, -1, -1, 255);
    // two-cycle expectation against a one-stage FF, d=0101
    run(1, 2, 1, 4, 16'b0000_0000_0000_1010, 1'b0, -1, -1, -1, -1, 255);
    // empty run
    run(0, 1, 1, 0, 16'h0000, 1'b0, -1, -1, -1, -1, 255);
    // 4-bit counters, all bits inverted
    run(2, 1, 1, 15, 16'h5a3c, 1'b1, -1, -1, -1, -1, 15);
    // reset during CHECK at bit 5, then a normal run
    run(0, 1, 1, 8, 16'b0000_0000_1110_0110, 1'b0, -1, -1, -1, 5, 255);
    run(0, 1, 1, 8, 16'b0000_0000_0100_1101, 1'b0, -1, -1, -1, -1, 255);
    // X on Q counts as a mismatch
    run(0, 1, 1, 4, 16'b0000_0000_0000_0110, 1'b0, -1, 2, -1, -1, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
